// File: rtl/delay_line_param.sv
// ---------------------------------------------------------------------------
// delay_line_param
//   Sample-strobed audio delay line built on a circular-buffer RAM. The read
//   address is the write pointer minus a runtime delay, so a delay change
//   takes effect on the very next sample. History that has not been written
//   since reset reads as zero. Out-of-range delays are clamped to DEPTH-1,
//   and delay 0 passes the input straight through.
//
//   Optional build macro: DELAY_FEEDBACK_EN
//     defined   : echo mode, RAM stores sat(in + delayed/2) (except delay 0)
//     undefined : RAM stores the raw input; no adder or saturation logic
//
// Parameters
//   WIDTH        sample width (two's complement)
//   AW           address width; DEPTH = 2**AW, max delay = DEPTH-1
//
// Ports
//   clk          system clock
//   reset        asynchronous reset, active-high
//   in_valid     input sample strobe, one sample per high cycle
//   in           input sample
//   delay_num    requested delay in samples, sampled with in_valid
//   out_valid    output strobe, two cycles after the matching in_valid
//   out          delayed sample
//   fill_done    high once DEPTH samples have been written since reset
//   delay_clamp  high while the last accepted delay_num was >= DEPTH
// ---------------------------------------------------------------------------
module delay_line_param #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [AW:0]      delay_num,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             fill_done,
    output logic             delay_clamp
);

    localparam int unsigned DEPTH   = 2 ** AW;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    // Storage and write-side state
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW:0]      fill;

    // Stage-1 pipeline registers
    logic             v1;
    logic [WIDTH-1:0] in1;
    logic [AW-1:0]    wp1;
    logic             zero1;
    logic             byp1;
    logic             fwd1;
    logic [WIDTH-1:0] fwd_data;
    logic [WIDTH-1:0] rd_ram;

    // Stage-0 combinational decode
    logic             clamp_c;
    logic [AW-1:0]    d_eff_c;
    logic [AW-1:0]    raddr_c;
    logic             zero_c;
    logic             fwd_c;
    logic [AW:0]      fill_inc_c;

    // Stage-1 combinational datapath
    logic [WIDTH-1:0] delayed_c;
    logic [WIDTH-1:0] wdata_c;

    // Delay clamp: any request with the top bit set is >= DEPTH
    always_comb begin
        clamp_c    = delay_num[AW];
        d_eff_c    = clamp_c ? {AW{1'b1}} : delay_num[AW-1:0];
        raddr_c    = wp - d_eff_c;
        zero_c     = ({1'b0, d_eff_c} > fill);
        // Delay 1 on a back-to-back sample targets the word stage 1 is
        // writing this same cycle, so take it from the write data instead.
        fwd_c      = v1 && (d_eff_c == AW'(1));
        fill_inc_c = fill + ONE_W;
    end

    // Masked delayed sample: zero where the source predates reset
    always_comb begin
        delayed_c = '0;
        if (!zero1) begin
            delayed_c = fwd1 ? fwd_data : rd_ram;
        end
    end

`ifdef DELAY_FEEDBACK_EN
    // Echo write data: in1 + delayed/2, saturated to the sample range
    logic [WIDTH:0] sum_c;

    always_comb begin
        sum_c   = {in1[WIDTH-1], in1}
                + {delayed_c[WIDTH-1], delayed_c[WIDTH-1], delayed_c[WIDTH-1:1]};
        wdata_c = sum_c[WIDTH-1:0];
        if (sum_c[WIDTH] != sum_c[WIDTH-1]) begin
            wdata_c = sum_c[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
        if (byp1) begin
            wdata_c = in1;
        end
    end
`else
    // Plain delay: store the raw input
    always_comb begin
        wdata_c = in1;
    end
`endif

    // Circular buffer: stage-1 write, stage-0 registered read (no reset)
    always_ff @(posedge clk) begin
        if (v1) begin
            mem[wp1] <= wdata_c;
        end
        if (in_valid) begin
            rd_ram <= mem[raddr_c];
        end
    end

    // Stage 0: pointers, fill tracking, status flags, stage-1 capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp          <= '0;
            fill        <= '0;
            fill_done   <= 1'b0;
            delay_clamp <= 1'b0;
            v1          <= 1'b0;
            in1         <= '0;
            wp1         <= '0;
            zero1       <= 1'b0;
            byp1        <= 1'b0;
            fwd1        <= 1'b0;
            fwd_data    <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                wp          <= wp + AW'(1);
                if (fill != DEPTH_W) begin
                    fill <= fill_inc_c;
                end
                fill_done   <= (fill_inc_c >= DEPTH_W);
                delay_clamp <= clamp_c;
                in1         <= in;
                wp1         <= wp;
                zero1       <= zero_c;
                byp1        <= (d_eff_c == '0);
                fwd1        <= fwd_c;
                fwd_data    <= wdata_c;
            end
        end
    end

    // Output register: bypass, masked zero or delayed sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                if (zero1) begin
                    out <= '0;
                end else if (byp1) begin
                    out <= in1;
                end else begin
                    out <= delayed_c;
                end
            end
        end
    end

endmodule
